// File: rtl/serv_dbg_req_pkg.sv
// serv_dbg_req_pkg: shared debug-request constants and FSM state encoding
package serv_dbg_req_pkg;
  typedef logic [2:0] dbg_state_t;
  localparam dbg_state_t ST_RUNNING   = 3'd0;
  localparam dbg_state_t ST_HALT_PEND = 3'd1;
  localparam dbg_state_t ST_HALTED    = 3'd2;
  localparam dbg_state_t ST_RESUMING  = 3'd3;
  localparam dbg_state_t ST_STEP      = 3'd4;
endpackage

// File: rtl/serv_sync_bit.sv
// serv_sync_bit: STAGES-deep flop chain bringing an asynchronous level into the clk domain
module serv_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= '0;
    else sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/serv_dbg_req.sv
// serv_dbg_req: debug halt/resume/step request sequencer for the SERV core
module serv_dbg_req
  import serv_dbg_req_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_haltreq,
  input  logic i_resumereq,
  input  logic i_step,
  input  logic i_ibus_ack,
  input  logic i_debug,
  input  logic i_dret,
  output logic o_debug_interrupt,
  output logic o_halted,
  output logic o_resume_flag,
  output logic o_resumeack,
  output logic o_halt_tmo
);
  logic hreq, rreq, dbg_q, step_q, dbg_rise, tmo_d;
  dbg_state_t state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  serv_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_halt (
    .clk_i(i_clk), .rst_ni(i_rst_n), .d_i(i_haltreq), .q_o(hreq)
  );
  serv_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_resume (
    .clk_i(i_clk), .rst_ni(i_rst_n), .d_i(i_resumereq), .q_o(rreq)
  );
  assign dbg_rise = i_debug && !dbg_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUNNING:   state_d = dbg_rise ? ST_HALTED : hreq ? ST_HALT_PEND : ST_RUNNING;
      ST_HALT_PEND: state_d = dbg_rise ? ST_HALTED : ST_HALT_PEND;
      ST_HALTED:    state_d = (rreq && !hreq) ? ST_RESUMING : ST_HALTED;
      ST_RESUMING:  state_d = i_dret ? (step_q ? ST_STEP : ST_RUNNING) : ST_RESUMING;
      ST_STEP:      state_d = dbg_rise ? ST_HALTED : i_ibus_ack ? ST_HALT_PEND : ST_STEP;
      default:      state_d = ST_RUNNING;
    endcase
  end
  // counter restarts on every entry so each halt attempt gets a full timeout window
  always_comb begin
    cnt_d = (state_d == ST_HALT_PEND && state_q != ST_HALT_PEND) ? '0 :
            (state_q == ST_HALT_PEND && cnt_q != '1) ? cnt_q + TMO_W'(1) : cnt_q;
    tmo_d = (state_d == ST_HALTED && state_q != ST_HALTED) ? 1'b0 :
            o_halt_tmo | (state_q == ST_HALT_PEND && state_d == ST_HALT_PEND && cnt_d == '1);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q           <= ST_RUNNING;
      dbg_q             <= 1'b0;
      step_q            <= 1'b0;
      cnt_q             <= '0;
      o_debug_interrupt <= 1'b0;
      o_resumeack       <= 1'b0;
      o_halt_tmo        <= 1'b0;
    end else begin
      state_q           <= state_d;
      dbg_q             <= i_debug;
      if (state_q == ST_HALTED && state_d == ST_RESUMING) step_q <= i_step;
      cnt_q             <= cnt_d;
      o_debug_interrupt <= state_d == ST_HALT_PEND;
      o_resumeack       <= state_q == ST_RESUMING && i_dret;
      o_halt_tmo        <= tmo_d;
    end
  end
  assign o_halted      = state_q == ST_HALTED;
  assign o_resume_flag = state_q == ST_RESUMING;
endmodule

// File: tb/tb_serv_dbg_req.sv
// tb_serv_dbg_req: directed and randomized checks of serv_dbg_req against a behavioural model
module tb_serv_dbg_req;
  localparam int SYNC = 2;
  localparam int TW = 4;
  localparam int TMO_LIMIT = (1 << TW) - 1;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_haltreq = 1'b0, i_resumereq = 1'b0, i_step = 1'b0;
  logic i_ibus_ack = 1'b0, i_debug = 1'b0, i_dret = 1'b0;
  logic o_debug_interrupt, o_halted, o_resume_flag, o_resumeack, o_halt_tmo;
  int checks = 0, errors = 0, cyc = 0;

  serv_dbg_req #(.SYNC_STAGES(SYNC), .TMO_W(TW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_haltreq(i_haltreq), .i_resumereq(i_resumereq),
    .i_step(i_step), .i_ibus_ack(i_ibus_ack), .i_debug(i_debug), .i_dret(i_dret),
    .o_debug_interrupt(o_debug_interrupt), .o_halted(o_halted), .o_resume_flag(o_resume_flag),
    .o_resumeack(o_resumeack), .o_halt_tmo(o_halt_tmo)
  );

  always #5 i_clk = ~i_clk;

  typedef enum {M_RUN, M_PEND, M_HALT, M_RES, M_STEP} mode_t;
  mode_t mode;
  bit hq[$], rq[$];
  bit dbg_prev, step_lat, exp_ack, exp_tmo;
  int pend_n;

  task automatic model_reset();
    mode = M_RUN;
    hq.delete();
    rq.delete();
    repeat (SYNC) begin hq.push_back(1'b0); rq.push_back(1'b0); end
    dbg_prev = 0; step_lat = 0; exp_ack = 0; exp_tmo = 0; pend_n = 0;
  endtask

  // advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    bit hr, rr, rise;
    mode_t nxt;
    if (!i_rst_n) begin model_reset(); return; end
    hr = hq.pop_front(); hq.push_back(i_haltreq);
    rr = rq.pop_front(); rq.push_back(i_resumereq);
    rise = i_debug && !dbg_prev;
    dbg_prev = i_debug;
    nxt = mode;
    case (mode)
      M_RUN:  if (rise) nxt = M_HALT; else if (hr) nxt = M_PEND;
      M_PEND: if (rise) nxt = M_HALT;
      M_HALT: if (rr && !hr) begin nxt = M_RES; step_lat = i_step; end
      M_RES:  if (i_dret) nxt = step_lat ? M_STEP : M_RUN;
      M_STEP: if (rise) nxt = M_HALT; else if (i_ibus_ack) nxt = M_PEND;
      default: nxt = M_RUN;
    endcase
    exp_ack = (mode == M_RES) && i_dret;
    if (nxt == M_PEND) begin
      pend_n = (mode == M_PEND) ? pend_n + 1 : 0;
      if (pend_n >= TMO_LIMIT) exp_tmo = 1;
    end
    if (nxt == M_HALT && mode != M_HALT) exp_tmo = 0;
    mode = nxt;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("model_int", o_debug_interrupt, mode == M_PEND);
    chk("model_halted", o_halted, mode == M_HALT);
    chk("model_resflag", o_resume_flag, mode == M_RES);
    chk("model_ack", o_resumeack, exp_ack);
    chk("model_tmo", o_halt_tmo, exp_tmo);
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
    check_model();
  endtask

  task automatic tickn(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_int"}, o_debug_interrupt, 1'b0);
    chk({tag, "_halted"}, o_halted, 1'b0);
    chk({tag, "_resflag"}, o_resume_flag, 1'b0);
    chk({tag, "_ack"}, o_resumeack, 1'b0);
    chk({tag, "_tmo"}, o_halt_tmo, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    // halt via request
    i_haltreq = 1'b1;
    tickn(2);
    chk("halt_int_c2", o_debug_interrupt, 1'b0);
    tick();
    chk("halt_int_c3", o_debug_interrupt, 1'b1);
    tickn(6);
    i_debug = 1'b1;
    tick();
    chk("halt_halted", o_halted, 1'b1);
    chk("halt_int_drop", o_debug_interrupt, 1'b0);
    // resume
    i_haltreq = 1'b0; i_resumereq = 1'b1;
    tickn(2);
    chk("res_flag_early", o_resume_flag, 1'b0);
    tick();
    chk("res_flag", o_resume_flag, 1'b1);
    i_resumereq = 1'b0; i_debug = 1'b0; i_dret = 1'b1;
    tick();
    i_dret = 1'b0;
    chk("res_ack", o_resumeack, 1'b1);
    chk("res_flag_clr", o_resume_flag, 1'b0);
    tick();
    chk("res_ack_pulse", o_resumeack, 1'b0);
    // ebreak entry
    i_debug = 1'b1;
    tick();
    chk("ebrk_halted", o_halted, 1'b1);
    chk("ebrk_no_int", o_debug_interrupt, 1'b0);
    // single step with simultaneous dret and ack
    i_step = 1'b1; i_resumereq = 1'b1;
    tickn(3);
    chk("step_resflag", o_resume_flag, 1'b1);
    i_resumereq = 1'b0; i_step = 1'b0; i_debug = 1'b0; i_dret = 1'b1; i_ibus_ack = 1'b1;
    tick();
    i_dret = 1'b0; i_ibus_ack = 1'b0;
    chk("step_ack", o_resumeack, 1'b1);
    chk("step_simul_ack", o_debug_interrupt, 1'b0);
    tickn(2);
    chk("step_wait", o_debug_interrupt, 1'b0);
    i_ibus_ack = 1'b1;
    tick();
    i_ibus_ack = 1'b0;
    chk("step_int", o_debug_interrupt, 1'b1);
    tick();
    i_debug = 1'b1;
    tick();
    chk("step_halted", o_halted, 1'b1);
    // timeout
    i_resumereq = 1'b1;
    tickn(3);
    i_resumereq = 1'b0; i_debug = 1'b0; i_dret = 1'b1;
    tick();
    i_dret = 1'b0;
    i_haltreq = 1'b1;
    tickn(3);
    chk("tmo_pend", o_debug_interrupt, 1'b1);
    tickn(14);
    chk("tmo_c14", o_halt_tmo, 1'b0);
    tick();
    chk("tmo_c15", o_halt_tmo, 1'b1);
    i_haltreq = 1'b0;
    tickn(4);
    chk("tmo_sticky", o_halt_tmo, 1'b1);
    chk("tmo_no_withdraw", o_debug_interrupt, 1'b1);
    i_debug = 1'b1;
    tick();
    chk("tmo_halted", o_halted, 1'b1);
    chk("tmo_clr", o_halt_tmo, 1'b0);
    // async reset mid-resuming
    i_resumereq = 1'b1;
    tickn(3);
    chk("rst_resflag", o_resume_flag, 1'b1);
    i_resumereq = 1'b0;
    #2;
    i_rst_n = 1'b0; i_debug = 1'b0;
    model_reset();
    #1;
    chk_all_zero("rst_async");
    @(negedge i_clk);
    i_rst_n = 1'b1; i_dret = 1'b1;
    tick();
    i_dret = 1'b0;
    chk("rst_stray_ack", o_resumeack, 1'b0);
    chk("rst_running", o_resume_flag, 1'b0);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        tick();
        i_rst_n = 1'b1;
        continue;
      end
      if ($urandom_range(0, 11) == 0) i_haltreq = ~i_haltreq;
      if ($urandom_range(0, 7) == 0) i_resumereq = ~i_resumereq;
      if ($urandom_range(0, 15) == 0) i_step = ~i_step;
      if ($urandom_range(0, 9) == 0) i_debug = ~i_debug;
      i_ibus_ack = ($urandom_range(0, 3) == 0);
      i_dret = ($urandom_range(0, 4) == 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serv_dbg_req.md
SERV_DBG_REQ -- requirements
Module: serv_dbg_req

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchroniser depth for i_haltreq and i_resumereq (minimum 2).
REQ-002 Parameter TMO_W, default 8, sets the halt-timeout counter width.
REQ-003 i_clk  in  1  core clock; single clock domain.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_haltreq  in  1  halt request level from the debug transport; asynchronous.
REQ-006 i_resumereq  in  1  resume request level from the debug transport; asynchronous.
REQ-007 i_step  in  1  single-step enable; quasi-static, sampled on leaving HALTED.
REQ-008 i_ibus_ack  in  1  core instruction-bus acknowledge.
REQ-009 i_debug  in  1  core debug-mode flag; rises when the debug trap is taken.
REQ-010 i_dret  in  1  one-cycle strobe when the core retires dret.
REQ-011 o_debug_interrupt  out  1  level to the core debug-interrupt input, which is edge-detected by the core.
REQ-012 o_halted  out  1  high in HALTED.
REQ-013 o_resume_flag  out  1  flag polled by debug ROM; high in RESUMING.
REQ-014 o_resumeack  out  1  one-cycle pulse on the i_dret that ends RESUMING.
REQ-015 o_halt_tmo  out  1  sticky flag: the halt was not acknowledged in time.

Function
REQ-016 i_haltreq and i_resumereq SHALL each pass through a SYNC_STAGES flip-flop chain; all logic uses the synchronised versions (hreq, rreq).
REQ-017 The FSM SHALL have the states RUNNING, HALT_PEND, HALTED, RESUMING and STEP.
REQ-018 RUNNING -> HALT_PEND when hreq=1.
REQ-019 HALT_PEND -> HALTED on a rising edge of i_debug (i_debug=1 and the registered previous value =0).
REQ-020 HALTED -> RESUMING when rreq=1 and hreq=0; if hreq=1, the FSM stays in HALTED.
REQ-021 RESUMING -> STEP on i_dret when i_step is sampled 1 at HALTED exit; otherwise RESUMING -> RUNNING on i_dret.
REQ-022 STEP -> HALT_PEND on the first i_ibus_ack; the core then traps before executing the second fetched instruction.
REQ-023 o_debug_interrupt SHALL be registered and equal 1 exactly in HALT_PEND; it drops in the cycle HALTED is entered, so a later request produces a fresh edge.
REQ-024 A rising edge of i_debug outside HALT_PEND (for example, ebreak-to-debug) SHALL move RUNNING or STEP -> HALTED.
REQ-025 The TMO_W-bit counter SHALL clear on entering HALT_PEND and increment each cycle in HALT_PEND, saturating at all-ones.
REQ-026 o_halt_tmo SHALL set when the counter reaches all-ones in HALT_PEND; it clears only on reset or on entering HALTED.
REQ-027 i_dret outside RESUMING SHALL be ignored, and o_resumeack SHALL not pulse.
REQ-028 In RUNNING, deassertion of hreq SHALL have no effect; in HALT_PEND, the request is not withdrawable and the FSM continues waiting for i_debug.
REQ-029 Simultaneous i_dret and i_ibus_ack in RESUMING SHALL NOT count toward STEP; only acks after entering STEP count.
REQ-030 All outputs SHALL be registered, and o_halted / o_resume_flag SHALL be decoded from the state register.

Reset
REQ-031 On i_rst_n=0, asynchronously: FSM=RUNNING, synchronisers=0, counter=0, and all outputs=0.
REQ-032 Reset asserted mid-operation (any state) SHALL abandon the operation; after release the FSM resumes from RUNNING, and a still-high haltreq re-enters HALT_PEND after SYNC_STAGES+1 cycles.

Structure
REQ-033 The FSM state encoding (3-bit localparams) SHALL reside in the shared serv debug package alongside the other debug constants.
REQ-034 The synchroniser SHALL be a sub-module, serv_sync_bit (parameter STAGES, async active-low reset), instantiated twice.
REQ-035 No other sub-modules are used; the target size is about 150-250 lines.

Verification
REQ-036 Halt: haltreq=1 -> o_debug_interrupt=1 three cycles later (SYNC_STAGES=2); i_debug rises at cycle 10 -> o_halted=1 and o_debug_interrupt=0 at cycle 11.
REQ-037 Resume: from HALTED, haltreq=0 and resumereq=1 -> o_resume_flag=1; a dret strobe -> one-cycle o_resumeack, then RUNNING and o_resume_flag=0.
REQ-038 Step: i_step=1, resume, then dret -> STEP; first ibus_ack -> o_debug_interrupt=1 the next cycle; a new i_debug edge -> HALTED.
REQ-039 Timeout: TMO_W=4, haltreq held with no i_debug -> o_halt_tmo=1 after 15 cycles in HALT_PEND; a later i_debug edge -> HALTED and o_halt_tmo=0.
REQ-040 Reset mid-RESUMING: i_rst_n low for 1 cycle -> all outputs 0 immediately (asynchronous); a stray dret afterwards produces no resumeack.
REQ-041 Ebreak entry: i_debug edge while RUNNING with haltreq=0 -> HALTED with no o_debug_interrupt pulse.
